// File: rtl/sdram_ctrlmod.sv
// SDRAM request sequencer: one-time init, periodic auto-refresh and single-word
// bus accesses turned into one-hot calls for sdram_funcmod.
// Optional macro SDRAM_CTRL_POSTED_WR_EN: writes are acked on the accepting edge.
module sdram_ctrlmod #(
    parameter int unsigned              REFRESH_CNT_W    = 16,
    parameter logic [REFRESH_CNT_W-1:0] REFRESH_INTERVAL = 16'd1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [24:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        ready_o,
    output logic [3:0]  call_o,
    input  logic        done_i,
    output logic [3:0]  f_sel_o,
    output logic [24:0] f_addr_o,
    output logic [31:0] f_data_o,
    input  logic [31:0] f_data_i
);

    localparam logic [3:0] CALL_WR   = 4'b1000;
    localparam logic [3:0] CALL_RD   = 4'b0100;
    localparam logic [3:0] CALL_REF  = 4'b0010;
    localparam logic [3:0] CALL_INIT = 4'b0001;
    localparam logic [REFRESH_CNT_W-1:0] WRAP_AT = REFRESH_INTERVAL - 1'b1;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        REFRESH,
        WRITE,
        READ,
        ACK,
        GAP
    } state_t;

    state_t                   state, state_nxt;
    logic [3:0]               call_nxt;
    logic                     ack_nxt;
    logic                     ready_nxt;
    logic [31:0]              data_nxt;
    logic [3:0]               f_sel_nxt;
    logic [24:0]              f_addr_nxt;
    logic [31:0]              f_data_nxt;
    logic [REFRESH_CNT_W-1:0] rcnt, rcnt_nxt;
    logic                     pending, pending_nxt;
    logic                     wrap;
    logic                     enter_ref;

    // Refresh interval counter: frozen until init completes, then free-running.
    always_comb begin
        wrap     = ready_o && (rcnt == WRAP_AT);
        rcnt_nxt = rcnt;
        if (ready_o) begin
            rcnt_nxt = wrap ? '0 : rcnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        call_nxt   = call_o;
        ack_nxt    = 1'b0;
        ready_nxt  = ready_o;
        data_nxt   = data_o;
        f_sel_nxt  = f_sel_o;
        f_addr_nxt = f_addr_o;
        f_data_nxt = f_data_o;
        enter_ref  = 1'b0;

        case (state)
            INIT: begin
                call_nxt = CALL_INIT;
                if (done_i) begin
                    call_nxt  = 4'b0000;
                    ready_nxt = 1'b1;
                    state_nxt = GAP;
                end
            end
            IDLE: begin
                // Refresh is checked first so a busy bus cannot starve it.
                if (pending) begin
                    call_nxt  = CALL_REF;
                    enter_ref = 1'b1;
                    state_nxt = REFRESH;
                end else if (req_i && ready_o) begin
                    f_sel_nxt  = sel_i;
                    f_addr_nxt = addr_i;
                    f_data_nxt = data_i;
                    if (we_i) begin
                        call_nxt  = CALL_WR;
                        state_nxt = WRITE;
`ifdef SDRAM_CTRL_POSTED_WR_EN
                        ack_nxt   = 1'b1;
`endif
                    end else begin
                        call_nxt  = CALL_RD;
                        state_nxt = READ;
                    end
                end
            end
            REFRESH: begin
                if (done_i) begin
                    call_nxt  = 4'b0000;
                    state_nxt = GAP;
                end
            end
            WRITE: begin
                if (done_i) begin
                    call_nxt  = 4'b0000;
`ifdef SDRAM_CTRL_POSTED_WR_EN
                    state_nxt = GAP;
`else
                    ack_nxt   = 1'b1;
                    state_nxt = ACK;
`endif
                end
            end
            READ: begin
                if (done_i) begin
                    call_nxt  = 4'b0000;
                    data_nxt  = f_data_i;
                    ack_nxt   = 1'b1;
                    state_nxt = ACK;
                end
            end
            // ACK lets the master drop req_i before IDLE can sample it again.
            ACK: begin
                state_nxt = IDLE;
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                call_nxt  = 4'b0000;
                state_nxt = INIT;
            end
        endcase
    end

    // A wrap on the same edge that enters REFRESH keeps the flag set.
    always_comb begin
        pending_nxt = pending;
        if (enter_ref) begin
            pending_nxt = 1'b0;
        end
        if (wrap) begin
            pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= INIT;
            call_o   <= 4'b0000;
            ack_o    <= 1'b0;
            ready_o  <= 1'b0;
            data_o   <= '0;
            f_sel_o  <= '0;
            f_addr_o <= '0;
            f_data_o <= '0;
            rcnt     <= '0;
            pending  <= 1'b0;
        end else begin
            state    <= state_nxt;
            call_o   <= call_nxt;
            ack_o    <= ack_nxt;
            ready_o  <= ready_nxt;
            data_o   <= data_nxt;
            f_sel_o  <= f_sel_nxt;
            f_addr_o <= f_addr_nxt;
            f_data_o <= f_data_nxt;
            rcnt     <= rcnt_nxt;
            pending  <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_sdram_ctrlmod.sv
// Self-checking bench for sdram_ctrlmod: a funcmod model with memory, a bus
// master task and a transaction-level reference memory for read data.
module tb_sdram_ctrlmod;

    localparam int RI       = 20;
    localparam int INIT_LAT = 40;
    localparam int REF_LAT  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [3:0]  sel_i = 4'h0;
    logic [24:0] addr_i = 25'h0;
    logic [31:0] data_i = 32'h0;
    logic [31:0] data_o;
    logic        ack_o;
    logic        ready_o;
    logic [3:0]  call_o;
    logic        done_i = 1'b0;
    logic [3:0]  f_sel_o;
    logic [24:0] f_addr_o;
    logic [31:0] f_data_o;
    logic [31:0] f_data_i = 32'h0;

    int checks = 0;
    int errors = 0;
    int pcyc = 0;
    int acc_lat = 4;

    logic [31:0] fmem    [logic [24:0]];
    logic [31:0] ref_mem [logic [24:0]];

    sdram_ctrlmod #(
        .REFRESH_CNT_W    (16),
        .REFRESH_INTERVAL (16'd20)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_i),
        .we_i     (we_i),
        .sel_i    (sel_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .data_o   (data_o),
        .ack_o    (ack_o),
        .ready_o  (ready_o),
        .call_o   (call_o),
        .done_i   (done_i),
        .f_sel_o  (f_sel_o),
        .f_addr_o (f_addr_o),
        .f_data_o (f_data_o),
        .f_data_i (f_data_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = nw[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] fmem_rd(input logic [24:0] a);
        return fmem.exists(a) ? fmem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [24:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // funcmod model: done_i in the lat-th cycle of a call; memory behind it.
    initial begin : funcmod_model
        int cnt;
        int lat;
        cnt = 0;
        lat = 1;
        forever begin
            @(posedge clk);
            #1;
            done_i = 1'b0;
            if (!rst_n || call_o == 4'b0000) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt == 1) begin
                    lat = (call_o == 4'b0001) ? INIT_LAT :
                          (call_o == 4'b0010) ? REF_LAT : acc_lat;
                end
                if (cnt == lat) begin
                    done_i = 1'b1;
                    if (call_o == 4'b1000) fmem[f_addr_o] = merge(fmem_rd(f_addr_o), f_data_o, f_sel_o);
                    if (call_o == 4'b0100) f_data_i = fmem_rd(f_addr_o);
                end
            end
        end
    end

    // Protocol monitor: one-hot calls, idle gap between calls, stable f_*,
    // and one refresh per elapsed interval counted from ready_o.
    initial begin : monitor
        logic [3:0]  prev_call;
        logic [60:0] prev_f;
        bit          rdy_seen;
        bit          outst;
        int          r;
        prev_call = 4'h0;
        prev_f    = '0;
        rdy_seen  = 1'b0;
        outst     = 1'b0;
        r         = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rdy_seen  = 1'b0;
                outst     = 1'b0;
                prev_call = 4'h0;
            end else begin
                if (call_o != 4'h0) check("call_onehot", 64'($countones(call_o)), 64'd1);
                if (prev_call != 4'h0 && call_o != 4'h0) begin
                    check("call_no_gap", 64'(call_o), 64'(prev_call));
                    check("f_stable", 64'({f_sel_o, f_addr_o, f_data_o}), 64'(prev_f));
                end
                if (ack_o) check("ack_ready", 64'(ready_o), 64'd1);
                if (!rdy_seen && ready_o) begin
                    rdy_seen = 1'b1;
                    r = pcyc;
                end
                if (rdy_seen) begin
                    if (call_o == 4'b0010 && prev_call != 4'b0010) begin
                        check("refresh_due", 64'(outst), 64'd1);
                        outst = 1'b0;
                    end
                    if (pcyc > r && (pcyc - r) % RI == 0) begin
                        check("refresh_missed", 64'(outst), 64'd0);
                        outst = 1'b1;
                    end
                end
                prev_call = call_o;
                prev_f    = {f_sel_o, f_addr_o, f_data_o};
            end
        end
    end

    task automatic access(input bit we, input logic [3:0] sel, input logic [24:0] addr,
                          input logic [31:0] data, input int lat, input bit wait_end,
                          output logic [31:0] rdata, output logic [3:0] first_call);
        int          acc_cyc, acks, starts, tail, iter, tail_len;
        bit          drop, fin;
        logic [3:0]  prev, call_at_ack, acc_code;
        logic [31:0] exp_rd;
        acc_cyc = 0; acks = 0; starts = 0; tail = 0; iter = 0;
        drop = 1'b0; fin = 1'b0;
        prev = 4'h0; call_at_ack = 4'h0;
        tail_len = wait_end ? 3 : 1;
        acc_code = we ? 4'b1000 : 4'b0100;
        first_call = 4'h0;
        rdata = 32'h0;
        exp_rd = ref_rd(addr);
        if (we) ref_mem[addr] = merge(ref_rd(addr), data, sel);
        @(posedge clk);
        #1;
        acc_lat = lat;
        req_i = 1'b1; we_i = we; sel_i = sel; addr_i = addr; data_i = data;
        while (tail < tail_len) begin
            @(posedge clk);
            #1;
            if (drop) req_i = 1'b0;
            @(negedge clk);
            iter++;
            if (iter > 300) begin
                check("access_timeout", 64'(iter), 64'd0);
                req_i = 1'b0;
                break;
            end
            if (first_call == 4'h0 && call_o != 4'h0) first_call = call_o;
            if ((call_o == 4'b1000 || call_o == 4'b0100) && call_o != prev) begin
                starts++;
                if (starts == 1) begin
                    we_i = 1'($urandom); sel_i = 4'($urandom);
                    addr_i = 25'($urandom); data_i = $urandom;
                end
            end
            if (call_o == acc_code) acc_cyc++;
            if (ack_o) begin
                acks++;
                if (acks == 1) begin
                    call_at_ack = call_o;
                    rdata = data_o;
                    drop = 1'b1;
                end
            end
            if (fin) tail++;
            else if (acks > 0 && (!wait_end || (acc_cyc > 0 && call_o == 4'h0))) fin = 1'b1;
            prev = call_o;
        end
        check("ack_count", 64'(acks), 64'd1);
        check("access_starts", 64'(starts), 64'd1);
        if (wait_end) check("call_cycles", 64'(acc_cyc), 64'(lat));
`ifdef SDRAM_CTRL_POSTED_WR_EN
        check("call_at_ack", 64'(call_at_ack), we ? 64'h8 : 64'h0);
`else
        check("call_at_ack", 64'(call_at_ack), 64'h0);
`endif
        if (!we) begin
            check("read_data", 64'(rdata), 64'(exp_rd));
            if (wait_end) check("data_hold", 64'(data_o), 64'(rdata));
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] rd;
        logic [3:0]  fc, prev;
        logic [24:0] pool [8];
        int          r, guard, ic, n_ack, lat;
        int          rises[$];
        bit          prev_done, w;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_call", 64'(call_o), 64'h0);
        check("rst_ack", 64'(ack_o), 64'h0);
        check("rst_ready", 64'(ready_o), 64'h0);
        check("rst_data", 64'(data_o), 64'h0);
        check("rst_f", 64'({f_sel_o, f_addr_o, f_data_o}), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Init: 0001 held for exactly INIT_LAT cycles, ready the cycle after done.
        ic = 0; guard = 0; prev_done = 1'b0;
        while (!ready_o && guard < 200) begin
            @(negedge clk);
            guard++;
            if (call_o == 4'b0001) ic++;
            if (ack_o) check("init_no_ack", 64'(ack_o), 64'h0);
            if (ready_o) begin
                check("ready_after_done", 64'(prev_done), 64'h1);
                check("init_call_clear", 64'(call_o), 64'h0);
            end
            prev_done = done_i;
        end
        check("ready_rise", 64'(ready_o), 64'h1);
        check("init_call_cycles", 64'(ic), 64'(INIT_LAT));
        r = pcyc;

        // Idle bus: pending sets on edge r+20k, refresh call follows one edge later.
        prev = 4'h0;
        while (pcyc < r + 65) begin
            @(negedge clk);
            if (call_o == 4'b0010 && prev != 4'b0010) rises.push_back(pcyc);
            prev = call_o;
        end
        check("refresh_count", 64'(rises.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            check("refresh_period", (k < rises.size()) ? 64'(rises[k]) : 64'hFFFF,
                  64'(r + 21 + RI * k));
        end

        // Request raised in the cycle refresh_pending sets: refresh runs first.
        while (pcyc < r + 79) @(negedge clk);
        access(1'b1, 4'hF, 25'h0000100, 32'hA5A50001, 5, 1'b1, rd, fc);
        check("refresh_first", 64'(fc), 64'h2);

        access(1'b1, 4'b0011, 25'h0123456, 32'hDEADBEEF, 8, 1'b1, rd, fc);
        check("wr_f_sel", 64'(f_sel_o), 64'h3);
        check("wr_f_addr", 64'(f_addr_o), 64'h0123456);
        check("wr_f_data", 64'(f_data_o), 64'hDEADBEEF);

        access(1'b0, 4'hF, 25'h0123456, 32'h0, 8, 1'b1, rd, fc);
        check("read_beef", 64'(rd), 64'h0000BEEF);

        // Reset in the middle of a read: no ack, back to init.
        @(posedge clk);
        #1;
        acc_lat = 20;
        req_i = 1'b1; we_i = 1'b0; sel_i = 4'hF; addr_i = 25'h0123456;
        guard = 0;
        while (call_o != 4'b0100 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("abort_read_started", 64'(call_o), 64'h4);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        req_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_call", 64'(call_o), 64'h0);
        check("abort_ready", 64'(ready_o), 64'h0);
        check("abort_ack", 64'(ack_o), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        guard = 0; n_ack = 0;
        while (!ready_o && guard < 200) begin
            @(negedge clk);
            guard++;
            if (ack_o) n_ack++;
        end
        check("reinit_ready", 64'(ready_o), 64'h1);
        check("abort_no_ack", 64'(n_ack), 64'h0);

`ifdef SDRAM_CTRL_POSTED_WR_EN
        // Posted write, then a read raised right away must see the written data.
        access(1'b1, 4'hF, 25'h0000200, 32'h12345678, 8, 1'b0, rd, fc);
        access(1'b0, 4'hF, 25'h0000200, 32'h0, 3, 1'b1, rd, fc);
        check("raw_order", 64'(rd), 64'h12345678);
`endif

        for (int k = 0; k < 8; k++) pool[k] = 25'($urandom);
        for (int t = 0; t < 40; t++) begin
            w   = 1'($urandom_range(0, 1));
            lat = $urandom_range(1, 8);
            access(w, 4'($urandom), pool[$urandom_range(0, 7)], $urandom, lat, 1'b1, rd, fc);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
